// File: rtl/alu_exec_seq.sv
// Sequential ALU execute unit with start/busy/done handshake; shifts iterate one bit per cycle.
// Define ALU_EXEC_FAST_SHIFT_EN to replace the iterative shift with a single-cycle barrel shift.
module alu_exec_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         gin,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_work, w_work_nxt;
  logic [SHAMT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_result, w_result_nxt;
  logic               r_zero, w_zero_nxt;
  logic [WIDTH-1:0]   w_alu;
  logic               w_lt;

  // Single-cycle operations; undefined codes (100/101) yield zero.
  always_comb begin
    w_lt  = $signed(a) < $signed(b);
    w_alu = '0;
    case (gin)
      3'b000:  w_alu = a & b;
      3'b001:  w_alu = a | b;
      3'b010:  w_alu = a + b;
      3'b110:  w_alu = a - b;
      3'b111:  w_alu = {{(WIDTH-1){1'b0}}, w_lt};
`ifdef ALU_EXEC_FAST_SHIFT_EN
      3'b011:  w_alu = b << shamt;
`endif
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_work_nxt   = r_work;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_EXEC_FAST_SHIFT_EN
          w_result_nxt = w_alu;
          w_zero_nxt   = (w_alu == '0);
          w_state_nxt  = S_DONE;
`else
          if (gin == 3'b011) begin
            w_work_nxt  = b;
            w_cnt_nxt   = shamt;
            w_state_nxt = S_SHIFT;
          end else begin
            w_result_nxt = w_alu;
            w_zero_nxt   = (w_alu == '0);
            w_state_nxt  = S_DONE;
          end
`endif
        end
      end
      S_SHIFT: begin
        // Oversized shift amounts simply shift the word out to zero.
        if (r_cnt == '0) begin
          w_result_nxt = r_work;
          w_zero_nxt   = (r_work == '0);
          w_state_nxt  = S_DONE;
        end else begin
          w_work_nxt = r_work << 1;
          w_cnt_nxt  = r_cnt - SHAMT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_work   <= w_work_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign zero   = r_zero;

endmodule
